pipelined_adder: RTL
====================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 Parameter STAGES, default 4, number of pipeline register stages; WIDTH SHALL be an integer multiple of STAGES, STAGES >= 1.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  operands a, b, cin presented this cycle.
REQ-006 Port in_ready  output  1  block accepts an operand set this cycle.
REQ-007 Port a  input  WIDTH  first operand, unsigned.
REQ-008 Port b  input  WIDTH  second operand, unsigned.
REQ-009 Port cin  input  1  carry in.
REQ-010 Port out_valid  output  1  sum, cout, ovf hold a valid result.
REQ-011 Port out_ready  input  1  consumer accepts the result this cycle.
REQ-012 Port sum  output  WIDTH  result bits.
REQ-013 Port cout  output  1  carry out of bit WIDTH-1.
REQ-014 Port ovf  output  1  signed two's-complement overflow of the result.

Function
REQ-015 The adder SHALL be split into STAGES slices of CHUNK = WIDTH/STAGES bits; slice k SHALL add bits [k*CHUNK +: CHUNK] in stage k using the carry registered by stage k-1 (stage 0 uses cin).
REQ-016 Operand bits not yet consumed and sum bits already produced SHALL travel with their stage, so sum, cout, ovf at the output always belong to one transaction.
REQ-017 Each stage SHALL carry a valid bit; latency from accepted input to out_valid SHALL be exactly STAGES cycles with no stall.
REQ-018 Transfer: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-019 Stall: stall = out_valid && !out_ready; while stall the whole pipeline SHALL hold, in_ready = !stall.
REQ-020 Without stall, throughput SHALL be one transaction per cycle; bubbles (in_valid=0) SHALL propagate as invalid stages.
REQ-021 While out_valid && !out_ready, sum, cout, ovf SHALL remain stable.
REQ-022 Arithmetic: {cout, sum} = a + b + cin modulo 2^(WIDTH+1); ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
REQ-023 Simultaneous accept and consume in one cycle SHALL both occur with no lost or duplicated result.
REQ-024 STAGES = 1: purely one registered add, latency 1, same handshake.

Reset
REQ-025 While rst_n = 0, all stage valid bits SHALL clear immediately; out_valid = 0, sum = 0, cout = 0, ovf = 0.
REQ-026 Reset mid-operation SHALL discard all in-flight transactions; none SHALL appear after release.
REQ-027 in_ready SHALL be 1 during and after reset (pipeline empty).

Configuration
REQ-028 Macro PIPELINED_ADDER_SUB_EN: when defined, an input port sub (1 bit) SHALL exist, captured with the operands; sub = 1 SHALL compute a - b as a + ~b + 1, ignoring cin, with cout = 1 meaning no borrow and ovf per REQ-022 applied to the inverted b.
REQ-029 Without PIPELINED_ADDER_SUB_EN, port sub SHALL not exist and only addition is performed.

Structure
REQ-030 Package adder_pkg SHALL hold default WIDTH and STAGES constants and the stage payload struct typedef (valid, partial sum, carry, remaining operands, sub flag).
REQ-031 One sub-module adder_stage SHALL implement a CHUNK-bit slice add plus its stage register with hold-on-stall; pipelined_adder SHALL instantiate STAGES copies via generate.

Verification
REQ-032 WIDTH=32, STAGES=4: a=0xFFFF_FFFF, b=0x1, cin=0 -> after 4 cycles sum=0x0, cout=1, ovf=0.
REQ-033 a=0x7FFF_FFFF, b=0x1, cin=0 -> sum=0x8000_0000, cout=0, ovf=1.
REQ-034 Back-to-back 8 random operand sets, out_ready=1 -> 8 results in order on consecutive cycles, first 4 cycles after first accept.
REQ-035 out_ready=0 for 3 cycles while pipeline full -> in_ready=0, sum/cout/ovf stable, no loss after out_ready returns to 1.
REQ-036 rst_n pulsed low with 3 transactions in flight -> out_valid=0 immediately, no result emitted after release.
REQ-037 With PIPELINED_ADDER_SUB_EN: sub=1, a=5, b=7 -> sum=0xFFFF_FFFE, cout=0, ovf=0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and stage payload for the pipelined adder.
// The payload is sized at the default width; narrower instances use its low bits.
package adder_pkg;

    localparam int unsigned ADDER_WIDTH  = 32;
    localparam int unsigned ADDER_STAGES = 4;

    // Everything one transaction needs as it moves down the pipe: sum bits
    // already produced, the ripple carry, the full operands (b already
    // inverted for subtraction), the operation flag and the final overflow.
    typedef struct packed {
        logic                   valid;
        logic [ADDER_WIDTH-1:0] sum;
        logic                   carry;
        logic [ADDER_WIDTH-1:0] a;
        logic [ADDER_WIDTH-1:0] b;
        logic                   sub;
        logic                   ovf;
    } stage_t;

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-bit slice of the pipelined adder plus its stage register.
// The register freezes while the pipeline output is stalled.
module adder_stage
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH,
    parameter int unsigned CHUNK = ADDER_WIDTH / ADDER_STAGES,
    parameter int unsigned IDX   = 0,
    parameter bit          LAST  = 1'b0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   stall,
    input  stage_t d,
    output stage_t q
);

    logic [CHUNK:0] part;
    stage_t         next;

    // Add this slice using the upstream carry; the rest of the payload rides along.
    always_comb begin
        part = {1'b0, d.a[IDX*CHUNK +: CHUNK]}
             + {1'b0, d.b[IDX*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, d.carry};
        next = d;
        next.sum[IDX*CHUNK +: CHUNK] = part[CHUNK-1:0];
        next.carry = part[CHUNK];
        if (LAST) begin
            next.ovf = (d.a[WIDTH-1] == d.b[WIDTH-1]) && (part[CHUNK-1] != d.a[WIDTH-1]);
        end
    end

    // Stage register: cleared by reset, held while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!stall) begin
            q <= next;
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple adder: WIDTH bits split into STAGES registered slices
// with a valid/ready handshake; a stalled output freezes the whole pipe.
// Optional macro PIPELINED_ADDER_SUB_EN adds a 'sub' input (a - b).
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = ADDER_WIDTH,
    parameter int unsigned STAGES = ADDER_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    stage_t head;
    stage_t link [STAGES];
    stage_t pipe [STAGES];
    stage_t last;
    logic   stall;
    logic   sub_op;
    logic   unused_fields;

`ifdef PIPELINED_ADDER_SUB_EN
    assign sub_op = sub;
`else
    assign sub_op = 1'b0;
`endif

    // Build the entry payload; subtraction is a + ~b + 1 so cin is ignored.
    always_comb begin
        head       = '0;
        head.valid = in_valid;
        head.a     = ADDER_WIDTH'(a);
        head.b     = ADDER_WIDTH'(sub_op ? ~b : b);
        head.carry = sub_op ? 1'b1 : cin;
        head.sub   = sub_op;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign link[k] = head;
        end else begin : g_next
            assign link[k] = pipe[k-1];
        end

        adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k),
            .LAST  (k == STAGES - 1)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .stall (stall),
            .d     (link[k]),
            .q     (pipe[k])
        );
    end

    assign last      = pipe[STAGES-1];
    assign stall     = last.valid && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = last.valid;
    assign sum       = last.sum[WIDTH-1:0];
    assign cout      = last.carry;
    assign ovf       = last.ovf;

    // Operands and op flag are fully consumed once the last slice has added.
    assign unused_fields = ^{last.a, last.b, last.sub};

endmodule
